fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the architectural PC register and issues one word-addressed read at a time to instruction memory.
- Presents fetched instructions to decode through a valid/ready IF/ID register.
- Consumes `next_pc` from branch_control as a redirect, which flushes in-flight and buffered fetches.
- Sits directly downstream of branch_control in the PC loop and upstream of decode.

Parameters:
- RESET_PC, 0: PC value loaded on reset. Width PC_WIDTH.
- Widths PC_WIDTH and INSTR_WIDTH come from cpuPkg; they are not module parameters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_load  input  1  redirect strobe: branch_control result is to be taken this cycle.
- next_pc  input  PC_WIDTH  redirect target from branch_control.
- imem_req  output  1  read request, single cycle, always accepted.
- imem_addr  output  PC_WIDTH  read address (word).
- imem_rvalid  input  1  read data valid; latency 1 or more cycles, at most one outstanding.
- imem_rdata  input  INSTR_WIDTH  read data.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_pc  output  PC_WIDTH  PC of the instruction in IF/ID.
- if_instr  output  INSTR_WIDTH  instruction in IF/ID.
- id_ready  input  1  decode accepts IF/ID this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=S_REQ.
  - if_valid=0, if_pc=0, if_instr=0.
  - Hold buffer cleared; imem_req=0 while reset is asserted.
  - The first request is issued in the first cycle after deassertion.
- Output slot free: slot_free = !if_valid || id_ready.
- IF/ID register:
  - A transfer occurs when if_valid && id_ready.
  - if_valid clears on a transfer unless the register is reloaded in the same cycle.
  - if_pc and if_instr are stable while if_valid && !id_ready.
- imem interface:
  - imem_addr = pc at all times.
  - imem_req = (state==S_REQ) && !pc_load.
- S_REQ:
  - pc_load: pc<=next_pc; stay S_REQ; no request issued.
  - Otherwise: issue request; go to S_WAIT.
- S_WAIT:
  - pc_load (with or without imem_rvalid): pc<=next_pc, if_valid<=0.
    - Goes to S_REQ if imem_rvalid is high that cycle; the response is discarded.
    - Goes to S_DRAIN otherwise.
  - imem_rvalid && slot_free: load IF/ID (if_pc<=pc, if_instr<=imem_rdata, if_valid<=1); pc<=pc+1; go to S_REQ.
  - imem_rvalid && !slot_free: capture {pc, imem_rdata} into the hold buffer; go to S_HOLD.
- S_HOLD:
  - pc_load: drop buffer, pc<=next_pc, if_valid<=0; go to S_REQ.
  - slot_free: load IF/ID from buffer; pc<=pc+1; go to S_REQ.
- S_DRAIN:
  - Waits for the orphaned response; no request is issued.
  - imem_rvalid: discard; go to S_REQ.
  - pc_load: pc<=next_pc and remain S_DRAIN, or go to S_REQ if imem_rvalid is high the same cycle.
- Priority: pc_load > imem_rvalid > id_ready.
  - A redirect flushes IF/ID even if decode accepts that same cycle; a concurrent accept is not suppressed.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so pc = all-ones wraps to 0.
- Redirect equal to the current pc (branch_control FIFO-wait case) is legal and simply refetches the same address.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency.
- Latency: pc_load to the new request is 1 cycle from S_REQ/S_HOLD, or the response-arrival cycle plus 1 from S_DRAIN.
- Reset mid-operation: state and outputs return to reset values immediately; any late imem_rvalid after reset is ignored because state is S_REQ.

Decomposition:
- cpuPkg gets:
  - INSTR_WIDTH (PC_WIDTH already exists there).
  - enum FetchState {S_REQ, S_WAIT, S_HOLD, S_DRAIN}, 2 bits.
- One natural sub-module: if_id_reg, the valid/ready IF/ID output register with load, flush and hold.
- The FSM, PC register and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, RESET_PC=0x10, rvalid 1 cycle after each req, id_ready=1 -> imem_addr 0x10,0x11,0x12 on cycles 0,2,4; IF/ID pairs (0x10,d0),(0x11,d1)…, each if_valid held 1 cycle.
- Backpressure: id_ready=0 for 5 cycles after the first instruction -> second response captured in the buffer (S_HOLD), no new req, if_pc stays 0x10; on id_ready=1, if_pc=0x11 next cycle, then req 0x12.
- Redirect in S_WAIT with 3-cycle latency: pc_load=1, next_pc=0x40 one cycle after the req -> if_valid=0, stale response discarded, next req addr=0x40 the cycle after that rvalid.
- Redirect coincident with rvalid and id_ready: pc_load, next_pc=0x80 -> IF/ID not loaded with the response, if_valid=0, req 0x80 next cycle.
- Wraparound: RESET_PC=all-ones -> second req addr=0.
- Self-redirect: next_pc=pc repeatedly -> same address refetched every time, no IF/ID output.
- Async reset asserted in S_HOLD -> outputs zero immediately without a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core types: datapath widths and the fetch FSM encoding.
package cpuPkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } FetchState;

  // Sequential word address; wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake, load and flush.
module if_id_reg
  import cpuPkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    load_pc,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  logic                   valid_q, valid_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  // Next-state: a transfer empties the slot, flush wins over load, load refills.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (valid_q && id_ready) valid_d = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end
  end

  // Register update; payload only changes on load so it is stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign if_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem reads, redirect handling.
//
// state   | meaning
// S_REQ   | issue a read at pc this cycle (unless redirected)
// S_WAIT  | read outstanding, waiting for imem_rvalid
// S_HOLD  | response parked in hold buffer until IF/ID frees up
// S_DRAIN | redirected while a read was outstanding; swallow its response
module fetch_stage
  import cpuPkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    next_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  input  logic                   id_ready
);

  FetchState              state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

  logic                   slot_free;
  logic                   ld;
  logic                   flush;
  logic [PC_WIDTH-1:0]    ld_pc;
  logic [INSTR_WIDTH-1:0] ld_instr;

  assign slot_free = !if_valid || id_ready;
  // Gated by rst_n so no request leaks out while reset is held.
  assign imem_req  = rst_n && (state_q == S_REQ) && !pc_load;
  assign imem_addr = pc_q;

  // FSM next-state; priority is pc_load > imem_rvalid > id_ready.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ld           = 1'b0;
    flush        = 1'b0;
    ld_pc        = pc_q;
    ld_instr     = imem_rdata;
    case (state_q)
      S_REQ: begin
        if (pc_load) pc_d = next_pc;
        else         state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pc_load) begin
          pc_d    = next_pc;
          flush   = 1'b1;
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          if (slot_free) begin
            ld      = 1'b1;
            pc_d    = pc_inc(pc_q);
            state_d = S_REQ;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        ld_pc    = hold_pc_q;
        ld_instr = hold_instr_q;
        if (pc_load) begin
          pc_d    = next_pc;
          flush   = 1'b1;
          state_d = S_REQ;
        end else if (slot_free) begin
          ld      = 1'b1;
          pc_d    = pc_inc(pc_q);
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (pc_load)     pc_d    = next_pc;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State, PC and hold buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld),
    .flush      (flush),
    .load_pc    (ld_pc),
    .load_instr (ld_instr),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem responder.
module tb_fetch_stage;
  import cpuPkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   pc_load;
  logic [PC_WIDTH-1:0]    next_pc;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   id_ready;

  logic                   imem_req, w_imem_req;
  logic [PC_WIDTH-1:0]    imem_addr, w_imem_addr;
  logic                   if_valid, w_if_valid;
  logic [PC_WIDTH-1:0]    if_pc, w_if_pc;
  logic [INSTR_WIDTH-1:0] if_instr, w_if_instr;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .next_pc(next_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr),
    .id_ready(id_ready)
  );

  function automatic logic [INSTR_WIDTH-1:0] dfun(input logic [PC_WIDTH-1:0] a);
    return 32'hD000_0000 | {16'h0000, a};
  endfunction

  // Memory model: capture request at negedge, answer lat cycles later for one cycle.
  initial begin : responder
    bit                  pend;
    int                  cnt;
    logic [PC_WIDTH-1:0] paddr;
    pend        = 1'b0;
    cnt         = 0;
    paddr       = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = dfun(paddr);
          pend        = 1'b0;
        end
      end
      @(negedge clk);
      if (rst_n && imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Reset, then return at the start of cycle 0 (first cycle after deassertion).
  task automatic do_reset();
    rst_n    = 1'b0;
    pc_load  = 1'b0;
    next_pc  = '0;
    id_ready = 1'b1;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n    = 1'b0;
    pc_load  = 1'b0;
    next_pc  = '0;
    id_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc",    32'(if_pc),    32'h0);
    chk("rst_if_instr", if_instr,      32'h0);
    chk("rst_req",      32'(imem_req), 32'h0);
    chk("rst_addr",     32'(imem_addr), 32'h10);
    chk("rst_wrap_addr", 32'(w_imem_addr), 32'hFFFF);

    // Streaming at latency 1
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("s_c0_req",  32'(imem_req),  32'h1);
    chk("s_c0_addr", 32'(imem_addr), 32'h10);
    nxt(); @(negedge clk);
    chk("s_c1_req",   32'(imem_req), 32'h0);
    chk("s_c1_valid", 32'(if_valid), 32'h0);
    nxt(); @(negedge clk);
    chk("s_c2_addr",  32'(imem_addr), 32'h11);
    chk("s_c2_req",   32'(imem_req),  32'h1);
    chk("s_c2_valid", 32'(if_valid),  32'h1);
    chk("s_c2_pc",    32'(if_pc),     32'h10);
    chk("s_c2_instr", if_instr,       32'hD000_0010);
    chk("wrap_addr",  32'(w_imem_addr), 32'h0000);
    nxt(); @(negedge clk);
    chk("s_c3_valid", 32'(if_valid), 32'h0);
    nxt(); @(negedge clk);
    chk("s_c4_addr",  32'(imem_addr), 32'h12);
    chk("s_c4_valid", 32'(if_valid),  32'h1);
    chk("s_c4_pc",    32'(if_pc),     32'h11);
    chk("s_c4_instr", if_instr,       32'hD000_0011);

    // Backpressure: id_ready low cycles 2..6
    lat = 1;
    do_reset();
    nxt(); nxt(); id_ready = 1'b0;
    nxt(); nxt(); @(negedge clk);
    chk("bp_c4_req", 32'(imem_req), 32'h0);
    chk("bp_c4_pc",  32'(if_pc),    32'h10);
    nxt(); nxt(); @(negedge clk);
    chk("bp_c6_req",   32'(imem_req), 32'h0);
    chk("bp_c6_valid", 32'(if_valid), 32'h1);
    chk("bp_c6_pc",    32'(if_pc),    32'h10);
    nxt(); id_ready = 1'b1; @(negedge clk);
    chk("bp_c7_pc",  32'(if_pc),    32'h10);
    chk("bp_c7_req", 32'(imem_req), 32'h0);
    nxt(); @(negedge clk);
    chk("bp_c8_pc",    32'(if_pc),     32'h11);
    chk("bp_c8_instr", if_instr,       32'hD000_0011);
    chk("bp_c8_req",   32'(imem_req),  32'h1);
    chk("bp_c8_addr",  32'(imem_addr), 32'h12);

    // Redirect in S_WAIT, latency 3
    lat = 3;
    do_reset();
    nxt(); pc_load = 1'b1; next_pc = 16'h0040; @(negedge clk);
    chk("rw_c1_req", 32'(imem_req), 32'h0);
    nxt(); pc_load = 1'b0; @(negedge clk);
    chk("rw_c2_req",  32'(imem_req),  32'h0);
    chk("rw_c2_addr", 32'(imem_addr), 32'h40);
    nxt(); @(negedge clk);
    chk("rw_c3_rvalid", 32'(imem_rvalid), 32'h1);
    chk("rw_c3_req",    32'(imem_req),    32'h0);
    chk("rw_c3_valid",  32'(if_valid),    32'h0);
    nxt(); @(negedge clk);
    chk("rw_c4_req",   32'(imem_req),  32'h1);
    chk("rw_c4_addr",  32'(imem_addr), 32'h40);
    chk("rw_c4_valid", 32'(if_valid),  32'h0);
    nxt(); nxt(); nxt(); nxt(); @(negedge clk);
    chk("rw_c8_valid", 32'(if_valid), 32'h1);
    chk("rw_c8_pc",    32'(if_pc),    32'h40);
    chk("rw_c8_instr", if_instr,      32'hD000_0040);

    // Redirect coincident with rvalid and id_ready
    lat = 1;
    do_reset();
    nxt(); pc_load = 1'b1; next_pc = 16'h0080; @(negedge clk);
    chk("rc_c1_rvalid", 32'(imem_rvalid), 32'h1);
    chk("rc_c1_req",    32'(imem_req),    32'h0);
    nxt(); pc_load = 1'b0; @(negedge clk);
    chk("rc_c2_valid", 32'(if_valid),  32'h0);
    chk("rc_c2_req",   32'(imem_req),  32'h1);
    chk("rc_c2_addr",  32'(imem_addr), 32'h80);
    nxt(); nxt(); @(negedge clk);
    chk("rc_c4_pc",    32'(if_pc), 32'h80);
    chk("rc_c4_instr", if_instr,   32'hD000_0080);

    // Redirect while holding a stalled response
    do_reset();
    nxt(); nxt(); id_ready = 1'b0;
    nxt(); nxt(); pc_load = 1'b1; next_pc = 16'h0020; @(negedge clk);
    chk("rh_c4_req",   32'(imem_req), 32'h0);
    chk("rh_c4_valid", 32'(if_valid), 32'h1);
    nxt(); pc_load = 1'b0; id_ready = 1'b1; @(negedge clk);
    chk("rh_c5_valid", 32'(if_valid),  32'h0);
    chk("rh_c5_req",   32'(imem_req),  32'h1);
    chk("rh_c5_addr",  32'(imem_addr), 32'h20);

    // Self-redirect to the current pc
    do_reset();
    pc_load = 1'b1; next_pc = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) nxt();
      @(negedge clk);
      chk("sr_hold_req",  32'(imem_req),  32'h0);
      chk("sr_hold_addr", 32'(imem_addr), 32'h10);
    end
    nxt(); pc_load = 1'b0; @(negedge clk);
    chk("sr_c3_req",  32'(imem_req),  32'h1);
    chk("sr_c3_addr", 32'(imem_addr), 32'h10);
    nxt(); pc_load = 1'b1; @(negedge clk);
    chk("sr_c4_req", 32'(imem_req), 32'h0);
    nxt(); pc_load = 1'b0; @(negedge clk);
    chk("sr_c5_req",   32'(imem_req),  32'h1);
    chk("sr_c5_addr",  32'(imem_addr), 32'h10);
    chk("sr_c5_valid", 32'(if_valid),  32'h0);

    // Async reset while in S_HOLD, no clock edge in between
    do_reset();
    nxt(); nxt(); id_ready = 1'b0;
    nxt(); nxt(); @(negedge clk);
    chk("ar_pre_valid", 32'(if_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(if_valid),  32'h0);
    chk("ar_pc",    32'(if_pc),     32'h0);
    chk("ar_instr", if_instr,       32'h0);
    chk("ar_req",   32'(imem_req),  32'h0);
    chk("ar_addr",  32'(imem_addr), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
